// File: rtl/victim_cache_ctrl.sv
// Fully-associative victim cache controller with FIFO (age-ordered)
// replacement, swap-on-hit lookup, dirty-victim writeback and
// hit/miss/writeback statistics counters.
module victim_cache_ctrl #(
   parameter int ENTRIES = 4,
   parameter int TAG_W   = 27,
   parameter int LINE_W  = 256,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lookup_valid,
   input  logic [TAG_W-1:0]  lookup_addr,
   output logic              lookup_ready,
   output logic              lookup_done,
   output logic              lookup_hit,
   output logic [LINE_W-1:0] lookup_line,
   output logic              lookup_dirty,
   input  logic              evict_valid,
   input  logic [TAG_W-1:0]  evict_addr,
   input  logic [LINE_W-1:0] evict_line,
   input  logic              evict_dirty,
   output logic              evict_ready,
   output logic              evict_done,
   output logic              pmem_write,
   output logic [TAG_W-1:0]  pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic              pmem_resp,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic [CNT_W-1:0]  wb_count
);

   localparam int            AW         = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam logic [AW-1:0] OLDEST_AGE = AW'(ENTRIES - 1);

   typedef enum logic [2:0] {IDLE, RESULT, INSERT, WB, DONE} state_t;

   state_t state_q, state_d;

   // Per-entry storage; age 0 is the newest valid entry.
   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] dirty_q;
   logic [TAG_W-1:0]   tag_q  [ENTRIES];
   logic [LINE_W-1:0]  line_q [ENTRIES];
   logic [AW-1:0]      age_q  [ENTRIES];

   // Latched request and registered lookup result.
   logic [TAG_W-1:0]   req_addr_q;
   logic [LINE_W-1:0]  req_line_q;
   logic               req_dirty_q;
   logic               hit_q;
   logic [AW-1:0]      hit_idx_q;
   logic [AW-1:0]      wb_idx_q;

   // Search results.
   logic               lk_hit;
   logic [AW-1:0]      lk_idx;
   logic               ins_match;
   logic [AW-1:0]      ins_match_idx;
   logic               free_found;
   logic [AW-1:0]      free_idx;
   logic [AW-1:0]      victim_idx;

   // Entry write decision from the FSM.
   logic               wr_en;
   logic               wr_refresh;
   logic [AW-1:0]      wr_idx;
   logic               wb_start;

   // Tag compare for the incoming lookup and the latched insert, plus victim selection.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
      lk_hit        = 1'b0;
      lk_idx        = '0;
      ins_match     = 1'b0;
      ins_match_idx = '0;
      victim_idx    = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && tag_q[i] == lookup_addr) begin
            lk_hit = 1'b1;
            lk_idx = AW'(i);
         end
         if (valid_q[i] && tag_q[i] == req_addr_q) begin
            ins_match     = 1'b1;
            ins_match_idx = AW'(i);
         end
         if (valid_q[i] && age_q[i] == OLDEST_AGE) begin
            victim_idx = AW'(i);
         end
      end
   end

   // Lowest-index invalid entry (scan downwards so the lowest index wins).
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = AW'(i);
         end
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d      = state_q;
      lookup_ready = 1'b0;
      evict_ready  = 1'b0;
      lookup_done  = 1'b0;
      lookup_hit   = 1'b0;
      lookup_line  = '0;
      lookup_dirty = 1'b0;
      evict_done   = 1'b0;
      pmem_write   = 1'b0;
      wr_en        = 1'b0;
      wr_refresh   = 1'b0;
      wr_idx       = '0;
      wb_start     = 1'b0;
      case (state_q)
         IDLE: begin
            lookup_ready = 1'b1;
            evict_ready  = evict_valid & ~lookup_valid;
            if (lookup_valid)     state_d = RESULT;
            else if (evict_valid) state_d = INSERT;
         end
         RESULT: begin
            lookup_done = 1'b1;
            lookup_hit  = hit_q;
            if (hit_q) begin
               lookup_line  = line_q[hit_idx_q];
               lookup_dirty = dirty_q[hit_idx_q];
            end
            state_d = IDLE;
         end
         INSERT: begin
            state_d = DONE;
            if (ins_match) begin
               wr_en      = 1'b1;
               wr_refresh = 1'b1;
               wr_idx     = ins_match_idx;
            end else if (free_found) begin
               wr_en  = 1'b1;
               wr_idx = free_idx;
            end else if (!dirty_q[victim_idx]) begin
               wr_en  = 1'b1;
               wr_idx = victim_idx;
            end else begin
               wb_start = 1'b1;
               state_d  = WB;
            end
         end
         WB: begin
            pmem_write = 1'b1;
            if (pmem_resp) begin
               wr_en   = 1'b1;
               wr_idx  = wb_idx_q;
               state_d = DONE;
            end
         end
         DONE: begin
            evict_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Request capture in IDLE; pure datapath, so it carries no reset.
   always_ff @(posedge clk) begin
      if (state_q == IDLE) begin
         if (lookup_valid) begin
            req_addr_q <= lookup_addr;
         end else if (evict_valid) begin
            req_addr_q  <= evict_addr;
            req_line_q  <= evict_line;
            req_dirty_q <= evict_dirty;
         end
      end
   end

   // Lookup result, writeback request registers and statistics counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_q      <= 1'b0;
         hit_idx_q  <= '0;
         wb_idx_q   <= '0;
         pmem_addr  <= '0;
         pmem_wdata <= '0;
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (state_q == IDLE && lookup_valid) begin
            hit_q     <= lk_hit;
            hit_idx_q <= lk_idx;
         end
         if (wb_start) begin
            wb_idx_q   <= victim_idx;
            pmem_addr  <= tag_q[victim_idx];
            pmem_wdata <= line_q[victim_idx];
         end
         if (state_q == RESULT) begin
            if (hit_q) hit_count  <= hit_count + CNT_W'(1);
            else       miss_count <= miss_count + CNT_W'(1);
         end
         if (state_q == WB && pmem_resp) wb_count <= wb_count + CNT_W'(1);
      end
   end

   // Valid bits and ages: remove on hit, refresh or place on insert.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
      end else if (state_q == RESULT && hit_q) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && age_q[i] > age_q[hit_idx_q]) age_q[i] <= age_q[i] - AW'(1);
         end
         valid_q[hit_idx_q] <= 1'b0;
         age_q[hit_idx_q]   <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && AW'(i) != wr_idx &&
                (!wr_refresh || age_q[i] < age_q[wr_idx])) begin
               age_q[i] <= age_q[i] + AW'(1);
            end
         end
         valid_q[wr_idx] <= 1'b1;
         age_q[wr_idx]   <= '0;
      end
   end

   // Line payload, tag and dirty bit of the written entry.
   always_ff @(posedge clk) begin
      // NOTE: tag/line/dirty storage is not reset; valid bits gate every use, so reset only clears valid and age.
      if (wr_en) begin
         tag_q[wr_idx]   <= req_addr_q;
         line_q[wr_idx]  <= req_line_q;
         dirty_q[wr_idx] <= wr_refresh ? (dirty_q[wr_idx] | req_dirty_q) : req_dirty_q;
      end
   end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Self-checking bench for victim_cache_ctrl: directed scenarios plus a random
// phase, all compared against a newest-first queue model of the cache.
module tb_victim_cache_ctrl;

   localparam int ENTRIES = 4;
   localparam int TAG_W   = 27;
   localparam int LINE_W  = 256;
   localparam int CNT_W   = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              lookup_valid;
   logic [TAG_W-1:0]  lookup_addr;
   logic              lookup_ready;
   logic              lookup_done;
   logic              lookup_hit;
   logic [LINE_W-1:0] lookup_line;
   logic              lookup_dirty;
   logic              evict_valid;
   logic [TAG_W-1:0]  evict_addr;
   logic [LINE_W-1:0] evict_line;
   logic              evict_dirty;
   logic              evict_ready;
   logic              evict_done;
   logic              pmem_write;
   logic [TAG_W-1:0]  pmem_addr;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_resp;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;
   logic [CNT_W-1:0]  wb_count;

   victim_cache_ctrl #(
      .ENTRIES(ENTRIES), .TAG_W(TAG_W), .LINE_W(LINE_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_ready(lookup_ready),
      .lookup_done(lookup_done), .lookup_hit(lookup_hit), .lookup_line(lookup_line),
      .lookup_dirty(lookup_dirty),
      .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_line(evict_line),
      .evict_dirty(evict_dirty), .evict_ready(evict_ready), .evict_done(evict_done),
      .pmem_write(pmem_write), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: queue position is the age (front = newest).
   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [LINE_W-1:0] line;
      logic              dirty;
   } ent_t;

   ent_t mq[$];
   int   exp_hit = 0;
   int   exp_miss = 0;
   int   exp_wb = 0;

   task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      check(tag, LINE_W'(obs), LINE_W'(exp));
   endtask

   task automatic checkt(input string tag, input logic [TAG_W-1:0] obs, input logic [TAG_W-1:0] exp);
      check(tag, LINE_W'(obs), LINE_W'(exp));
   endtask

   task automatic checkc(input string tag, input logic [CNT_W-1:0] obs, input int exp);
      check(tag, LINE_W'(obs), LINE_W'(CNT_W'(exp)));
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] r;
      for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_lookup(input logic [TAG_W-1:0] a, output logic hit,
                               output logic [LINE_W-1:0] line, output logic dirty);
      hit = 1'b0; line = '0; dirty = 1'b0;
      for (int i = 0; i < mq.size(); i++) begin
         if (!hit && mq[i].tag == a) begin
            hit = 1'b1; line = mq[i].line; dirty = mq[i].dirty;
            mq.delete(i);
            break;
         end
      end
      if (hit) exp_hit++;
      else     exp_miss++;
   endtask

   task automatic model_insert(input logic [TAG_W-1:0] a, input logic [LINE_W-1:0] l, input logic d,
                               output logic wb, output logic [TAG_W-1:0] wt, output logic [LINE_W-1:0] wl);
      ent_t e;
      logic merged;
      wb = 1'b0; wt = '0; wl = '0; merged = d;
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].tag == a) begin
            merged = mq[i].dirty | d;
            mq.delete(i);
            break;
         end
      end
      if (mq.size() == ENTRIES) begin
         e = mq.pop_back();
         wb = e.dirty; wt = e.tag; wl = e.line;
      end
      e.tag = a; e.line = l; e.dirty = merged;
      mq.push_front(e);
   endtask

   // Remainder of an insert, starting #1 after its acceptance edge.
   task automatic finish_evict(input logic wb, input logic [TAG_W-1:0] wt,
                               input logic [LINE_W-1:0] wl, input int delay);
      check1("insert_done_early", evict_done, 1'b0);
      check1("insert_busy_ready", lookup_ready, 1'b0);
      @(posedge clk); #1;
      if (!wb) begin
         check1("evict_done", evict_done, 1'b1);
         check1("no_pmem_write", pmem_write, 1'b0);
      end else begin
         check1("pmem_write", pmem_write, 1'b1);
         checkt("pmem_addr", pmem_addr, wt);
         check("pmem_wdata", pmem_wdata, wl);
         check1("wb_done_early", evict_done, 1'b0);
         for (int k = 0; k < delay; k++) begin
            @(posedge clk); #1;
            check1("pmem_write_hold", pmem_write, 1'b1);
            checkt("pmem_addr_hold", pmem_addr, wt);
            check("pmem_wdata_hold", pmem_wdata, wl);
         end
         @(negedge clk); pmem_resp = 1'b1;
         @(posedge clk); #1; pmem_resp = 1'b0;
         exp_wb++;
         check1("wb_evict_done", evict_done, 1'b1);
         check1("pmem_write_drop", pmem_write, 1'b0);
         checkc("wb_count", wb_count, exp_wb);
      end
      @(posedge clk); #1;
      check1("evict_done_pulse", evict_done, 1'b0);
      check1("back_idle", lookup_ready, 1'b1);
   endtask

   task automatic do_evict(input logic [TAG_W-1:0] a, input logic [LINE_W-1:0] l,
                           input logic d, input int delay);
      logic wb; logic [TAG_W-1:0] wt; logic [LINE_W-1:0] wl;
      model_insert(a, l, d, wb, wt, wl);
      @(negedge clk);
      evict_valid = 1'b1; evict_addr = a; evict_line = l; evict_dirty = d;
      #1 check1("evict_ready", evict_ready, 1'b1);
      @(posedge clk); #1; evict_valid = 1'b0;
      finish_evict(wb, wt, wl, delay);
   endtask

   // Checks the RESULT cycle (#1 after acceptance) and the following counters.
   task automatic lookup_result(input logic hit, input logic [LINE_W-1:0] line, input logic dirty);
      check1("lookup_done", lookup_done, 1'b1);
      check1("lookup_hit", lookup_hit, hit);
      if (hit) begin
         check("lookup_line", lookup_line, line);
         check1("lookup_dirty", lookup_dirty, dirty);
      end
      @(posedge clk); #1;
      check1("lookup_done_pulse", lookup_done, 1'b0);
      checkc("hit_count", hit_count, exp_hit);
      checkc("miss_count", miss_count, exp_miss);
   endtask

   task automatic do_lookup(input logic [TAG_W-1:0] a);
      logic hit; logic [LINE_W-1:0] line; logic dirty;
      model_lookup(a, hit, line, dirty);
      @(negedge clk);
      lookup_valid = 1'b1; lookup_addr = a;
      #1 check1("lookup_ready", lookup_ready, 1'b1);
      @(posedge clk); #1; lookup_valid = 1'b0;
      lookup_result(hit, line, dirty);
   endtask

   // Lookup and evict offered together: lookup first, insert on the next IDLE cycle.
   task automatic do_both(input logic [TAG_W-1:0] la, input logic [TAG_W-1:0] ea,
                          input logic [LINE_W-1:0] l, input logic d, input int delay);
      logic hit; logic [LINE_W-1:0] line; logic dirty;
      logic wb; logic [TAG_W-1:0] wt; logic [LINE_W-1:0] wl;
      model_lookup(la, hit, line, dirty);
      model_insert(ea, l, d, wb, wt, wl);
      @(negedge clk);
      lookup_valid = 1'b1; lookup_addr = la;
      evict_valid = 1'b1; evict_addr = ea; evict_line = l; evict_dirty = d;
      #1;
      check1("both_evict_ready", evict_ready, 1'b0);
      check1("both_lookup_ready", lookup_ready, 1'b1);
      @(posedge clk); #1; lookup_valid = 1'b0;
      check1("both_result_evict_ready", evict_ready, 1'b0);
      lookup_result(hit, line, dirty);
      check1("pending_evict_ready", evict_ready, 1'b1);
      @(posedge clk); #1; evict_valid = 1'b0;
      finish_evict(wb, wt, wl, delay);
   endtask

   initial begin
      logic wb; logic [TAG_W-1:0] wt; logic [LINE_W-1:0] wl;
      rst = 1'b1;
      lookup_valid = 1'b0; lookup_addr = '0;
      evict_valid = 1'b0; evict_addr = '0; evict_line = '0; evict_dirty = 1'b0;
      pmem_resp = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check1("rst_lookup_ready", lookup_ready, 1'b1);
      check1("rst_evict_ready", evict_ready, 1'b0);
      check1("rst_lookup_done", lookup_done, 1'b0);
      check1("rst_evict_done", evict_done, 1'b0);
      check1("rst_pmem_write", pmem_write, 1'b0);
      checkt("rst_pmem_addr", pmem_addr, '0);
      check("rst_lookup_line", lookup_line, '0);
      checkc("rst_hit_count", hit_count, 0);
      checkc("rst_miss_count", miss_count, 0);
      checkc("rst_wb_count", wb_count, 0);
      @(negedge clk); rst = 1'b0;

      // Fill with four clean lines; no writeback expected.
      for (int i = 0; i < 4; i++) do_evict(TAG_W'(32'h10 + i), rand_line(), 1'b0, 0);

      // Hit on B removes it; second lookup misses.
      do_lookup(TAG_W'(32'h11));
      do_lookup(TAG_W'(32'h11));

      // Build a full cache whose oldest entry (0x14) is dirty, then insert 0x20.
      do_evict(TAG_W'(32'h14), rand_line(), 1'b1, 0);
      do_evict(TAG_W'(32'h10), rand_line(), 1'b1, 0);
      do_evict(TAG_W'(32'h15), rand_line(), 1'b0, 0);
      do_evict(TAG_W'(32'h16), rand_line(), 1'b0, 0);
      do_evict(TAG_W'(32'h20), rand_line(), 1'b0, 5);
      do_lookup(TAG_W'(32'h20));

      // Simultaneous lookup and evict.
      do_both(TAG_W'(32'h16), TAG_W'(32'h21), rand_line(), 1'b0, 0);

      // Same address inserted clean then dirty: one entry, new data, dirty.
      do_evict(TAG_W'(32'h30), rand_line(), 1'b0, 0);
      do_evict(TAG_W'(32'h30), rand_line(), 1'b1, 2);
      do_lookup(TAG_W'(32'h30));
      do_lookup(TAG_W'(32'h30));

      // pmem_resp outside WB is ignored.
      @(negedge clk); pmem_resp = 1'b1;
      @(posedge clk); #1;
      checkc("stray_resp_wb_count", wb_count, exp_wb);
      check1("stray_resp_pmem_write", pmem_write, 1'b0);
      @(negedge clk); pmem_resp = 1'b0;

      // Random traffic over a small tag set to force churn and writebacks.
      for (int n = 0; n < 200; n++) begin
         int op;
         logic [TAG_W-1:0] ta, tb;
         op = $urandom_range(0, 9);
         ta = TAG_W'(32'h40 + $urandom_range(0, 7));
         tb = TAG_W'(32'h40 + $urandom_range(0, 7));
         if (op < 4)      do_lookup(ta);
         else if (op < 9) do_evict(ta, rand_line(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
         else             do_both(ta, tb, rand_line(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
      checkc("rand_hit_count", hit_count, exp_hit);
      checkc("rand_miss_count", miss_count, exp_miss);
      checkc("rand_wb_count", wb_count, exp_wb);

      // Reset during writeback.
      for (int i = 0; i < 4; i++) do_evict(TAG_W'(32'h50 + i), rand_line(), 1'b1, 1);
      model_insert(TAG_W'(32'h54), rand_line(), 1'b1, wb, wt, wl);
      check1("pre_rst_wb_expected", wb, 1'b1);
      @(negedge clk);
      evict_valid = 1'b1; evict_addr = TAG_W'(32'h54); evict_line = rand_line(); evict_dirty = 1'b1;
      @(posedge clk); #1; evict_valid = 1'b0;
      @(posedge clk); #1;
      check1("mid_wb_pmem_write", pmem_write, 1'b1);
      checkt("mid_wb_pmem_addr", pmem_addr, wt);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check1("rst_wb_pmem_write", pmem_write, 1'b0);
      check1("rst_wb_lookup_ready", lookup_ready, 1'b1);
      checkc("rst_wb_hit_count", hit_count, 0);
      checkc("rst_wb_miss_count", miss_count, 0);
      checkc("rst_wb_wb_count", wb_count, 0);
      @(negedge clk); rst = 1'b0;
      mq.delete();
      exp_hit = 0; exp_miss = 0; exp_wb = 0;
      for (int i = 0; i < 5; i++) do_lookup(TAG_W'(32'h50 + i));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
